// File: rtl/bram_stream_reader.sv
// Streams a run of DBITS-wide BRAM words as SBITS segments, LSB first, on valid/ready.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | RD_ADDR presented, BRAM samples it at the closing edge
// LOAD  | RD_DATA captured into the shift register, address advanced
// SHIFT | streaming the segments of the current word
// FIN   | one-cycle done pulse
module bram_stream_reader #(
  parameter int ABITS = 8,
  parameter int DBITS = 512,
  parameter int SBITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ABITS-1:0] base_addr,
  input  logic [ABITS:0]   num_words,
  output logic             busy,
  output logic             done,
  output logic [ABITS-1:0] RD_ADDR,
  input  logic [DBITS-1:0] RD_DATA,
  output logic [SBITS-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int NSEG = DBITS / SBITS;
  localparam int SEGW = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, FIN} state_e;

  state_e           state_q, state_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [ABITS:0]   rem_q, rem_d;
  logic [SEGW-1:0]  seg_q, seg_d;
  logic [DBITS-1:0] sh_q, sh_d;
  logic             seg_end;

  assign seg_end = (seg_q == SEGW'(NSEG - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    seg_d   = seg_q;
    sh_d    = sh_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            state_d = FIN;
          end else begin
            addr_d  = base_addr;
            rem_d   = num_words;
            state_d = FETCH;
          end
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        sh_d    = RD_DATA;
        seg_d   = '0;
        rem_d   = rem_q - (ABITS+1)'(1);
        addr_d  = addr_q + ABITS'(1);
        state_d = SHIFT;
      end
      SHIFT: begin
        if (out_ready) begin
          sh_d  = sh_q >> SBITS;
          seg_d = seg_q + SEGW'(1);
          if (seg_end) state_d = (rem_q != '0) ? FETCH : FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      seg_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      seg_q   <= seg_d;
      sh_q    <= sh_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign out_valid = (state_q == SHIFT);
  assign out_data  = sh_q[SBITS-1:0];
  assign out_last  = out_valid && seg_end && (rem_q == '0);
  assign RD_ADDR   = addr_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: segment-queue model checked every negedge plus literal pins.
module tb_bram_stream_reader;

  localparam int ABITS = 8;
  localparam int DBITS = 512;
  localparam int SBITS = 32;
  localparam int NSEG  = DBITS / SBITS;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [ABITS-1:0] base_addr;
  logic [ABITS:0]   num_words;
  logic             busy, done, out_valid, out_last, out_ready;
  logic [ABITS-1:0] RD_ADDR;
  logic [DBITS-1:0] RD_DATA;
  logic [SBITS-1:0] out_data;

  logic [DBITS-1:0] mem [2**ABITS];

  int n_tests = 0;
  int n_fail  = 0;

  bram_stream_reader #(.ABITS(ABITS), .DBITS(DBITS), .SBITS(SBITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .RD_ADDR(RD_ADDR),
    .RD_DATA(RD_DATA), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) RD_DATA <= mem[RD_ADDR];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a command becomes a queue of segments; each word costs two idle cycles first.
  logic [SBITS-1:0] exp_q[$];
  logic             m_idle = 1'b1, m_active = 1'b0, m_done_due = 1'b0;
  int               m_gap = 0, m_seg = 0;
  logic [ABITS-1:0] m_addr = '0;
  logic             p_stall = 1'b0, p_last = 1'b0;
  logic [SBITS-1:0] p_data = '0;
  logic             m_valid;
  logic [ABITS-1:0] a;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_last", out_last, 0);
      chk("rst_addr", RD_ADDR, 0);
      chk("rst_data", out_data, 0);
      exp_q.delete();
      m_idle = 1; m_active = 0; m_done_due = 0; m_gap = 0; m_seg = 0; m_addr = '0;
      p_stall = 0;
    end else begin
      m_valid = m_active && (m_gap == 0);
      chk("busy", busy, !m_idle);
      chk("done", done, m_done_due);
      chk("rd_addr", RD_ADDR, m_addr);
      chk("out_valid", out_valid, m_valid);
      if (m_valid && out_valid && exp_q.size() > 0) begin
        chk("out_data", out_data, exp_q[0]);
        chk("out_last", out_last, exp_q.size() == 1);
      end
      if (p_stall) begin
        chk("hold_data", out_data, p_data);
        chk("hold_last", out_last, p_last);
      end
      if (m_done_due) begin
        m_done_due = 0;
        m_idle = 1;
      end else if (m_idle && start) begin
        m_idle = 0;
        if (num_words == 0) begin
          m_done_due = 1;
        end else begin
          m_addr = base_addr;
          for (int w = 0; w < int'(num_words); w++) begin
            a = base_addr + ABITS'(w);
            for (int s = 0; s < NSEG; s++) exp_q.push_back(mem[a][s*SBITS +: SBITS]);
          end
          m_active = 1; m_gap = 2; m_seg = 0;
        end
      end else if (m_active) begin
        if (m_gap > 0) begin
          if (m_gap == 1) m_addr = m_addr + 1'b1;
          m_gap--;
        end else if (out_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_seg++;
          if (m_seg == NSEG) begin
            m_seg = 0;
            if (exp_q.size() == 0) begin
              m_active = 0;
              m_done_due = 1;
            end else begin
              m_gap = 2;
            end
          end
        end
      end
      p_stall = out_valid && !out_ready;
      p_data  = out_data;
      p_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int b, input int n);
    start = 1; base_addr = ABITS'(b); num_words = (ABITS+1)'(n);
    tick();
    start = 0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!done && k < 2000) begin
      tick();
      k++;
    end
    chk({nm, "_done_seen"}, done, 1);
    tick();
  endtask

  logic [SBITS-1:0] tmp;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; start = 0; base_addr = '0; num_words = '0; out_ready = 1;
    for (int i = 0; i < 2**ABITS; i++)
      for (int s = 0; s < NSEG; s++) mem[i][s*SBITS +: SBITS] = $urandom;
    for (int s = 0; s < NSEG; s++) begin
      mem[5][s*SBITS +: SBITS]   = SBITS'(s);
      mem[255][s*SBITS +: SBITS] = SBITS'(32'h100 + s);
      mem[0][s*SBITS +: SBITS]   = SBITS'(32'h200 + s);
    end
    tick(); tick();
    rst_n = 1;
    tick();

    // single word
    issue(5, 1);
    chk("sw_busy_c1", busy, 1);
    tick(); tick();
    chk("sw_valid_c3", out_valid, 1);
    chk("sw_data_c3", out_data, 0);
    chk("sw_last_c3", out_last, 0);
    repeat (15) tick();
    chk("sw_data_c18", out_data, 15);
    chk("sw_last_c18", out_last, 1);
    tick();
    chk("sw_done_c19", done, 1);
    wait_done("sw");

    // zero count
    issue(9, 0);
    chk("z_done_c1", done, 1);
    chk("z_busy_c1", busy, 1);
    chk("z_addr_c1", RD_ADDR, 6);
    tick();
    chk("z_done_c2", done, 0);
    chk("z_busy_c2", busy, 0);
    chk("z_addr_c2", RD_ADDR, 6);

    // wrap-around
    issue(255, 2);
    chk("wr_addr_c1", RD_ADDR, 255);
    tick(); tick();
    chk("wr_addr_c3", RD_ADDR, 0);
    chk("wr_data_c3", out_data, 32'h100);
    repeat (16) tick();
    chk("wr_addr_c19", RD_ADDR, 0);
    chk("wr_valid_c19", out_valid, 0);
    repeat (17) tick();
    chk("wr_data_c36", out_data, 32'h20F);
    chk("wr_last_c36", out_last, 1);
    wait_done("wr");

    // backpressure with a 5-cycle stall mid-word
    issue(20, 2);
    for (int c = 1; c < 600 && !done; c++) begin
      out_ready = (c >= 8 && c < 13) ? 1'b0 : 1'($urandom_range(0, 1));
      if (c == 12) chk("bp_stall_valid", out_valid, 1);
      tick();
    end
    out_ready = 1;
    wait_done("bp");

    // start while busy is ignored
    issue(40, 1);
    repeat (4) tick();
    start = 1; base_addr = 8'd60; num_words = 9'd5;
    tick();
    start = 0;
    wait_done("sb");
    chk("sb_idle_a", busy, 0);
    tick();
    chk("sb_idle_b", busy, 0);
    chk("sb_addr", RD_ADDR, 41);

    // reset on beat 7 of a three-word command
    issue(10, 3);
    repeat (8) tick();
    tmp = mem[10][6*SBITS +: SBITS];
    chk("rs_beat7", out_data, tmp);
    rst_n = 0;
    #1;
    chk("rs_valid", out_valid, 0);
    chk("rs_busy", busy, 0);
    chk("rs_data", out_data, 0);
    chk("rs_addr", RD_ADDR, 0);
    tick(); tick();
    rst_n = 1;
    tick();
    issue(100, 1);
    tick(); tick();
    tmp = mem[100][SBITS-1:0];
    chk("rs_fresh_data", out_data, tmp);
    wait_done("rs_fresh");
    chk("rs_model_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side master for the dual-write/single-read operand BRAM. On a start command it fetches a contiguous run of DBITS-wide words, starting at a base address. It then serializes each word into SBITS-wide segments, least significant first, on a valid/ready stream. It feeds the RSA datapath's narrow operand input from words the loaders have written into the BRAM.

## Interface
Parameters:
- ABITS, 8, BRAM address width
- DBITS, 512, BRAM word width
- SBITS, 32, output segment width; DBITS must be an integer multiple of SBITS; NSEG = DBITS/SBITS

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe, sampled only in IDLE
- base_addr  in  ABITS  first word address, captured with start
- num_words  in  ABITS+1  words to stream, 0..2^ABITS, captured with start
- busy  out  1  high from the cycle after accepted start until done pulse (inclusive)
- done  out  1  one-cycle pulse when the command completes
- RD_ADDR  out  ABITS  BRAM read address, registered
- RD_DATA  in  DBITS  BRAM read data, valid the cycle after the BRAM samples RD_ADDR
- out_data  out  SBITS  current segment
- out_valid  out  1  segment valid
- out_ready  in  1  consumer accepts segment when out_valid && out_ready
- out_last  out  1  high with the final segment of the final word

## Operation
- States: IDLE, FETCH, LOAD, SHIFT, FIN.
- IDLE:
  - start=1 and num_words=0: go to FIN; no BRAM access.
  - start=1 and num_words>0: capture base_addr into RD_ADDR and num_words into the remaining-word counter; go to FETCH.
- FETCH: one cycle. RD_ADDR is stable and the BRAM samples it at the closing edge. Go to LOAD.
- LOAD: one cycle. At the closing edge:
  - RD_DATA is loaded into the DBITS shift register.
  - The segment counter is cleared.
  - The remaining-word counter is decremented.
  - RD_ADDR is incremented, wrapping modulo 2^ABITS (address 2^ABITS-1 is followed by 0).
  - Go to SHIFT.
- SHIFT:
  - out_valid=1 and out_data = shift register bits [SBITS-1:0].
  - On each handshake, shift right by SBITS and increment the segment counter.
  - On the handshake of segment NSEG-1: go to FETCH if words remain, otherwise go to FIN.
- out_last = (state==SHIFT) && (segment counter==NSEG-1) && (remaining words==0).
- FIN: done=1 for one cycle, then go to IDLE.
- start is ignored in every state except IDLE.
- The reader does not arbitrate writes. Any BRAM write to an in-range address during busy gives undefined stream content. This is the caller's responsibility.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE. busy, done, out_valid and out_last are all 0. RD_ADDR and out_data are 0. All counters and the shift register are 0.
- Reset asserted mid-command aborts the command immediately. There is no done pulse and out_valid drops within the same cycle as the reset assertion.
- Latency for start accepted at edge E0:
  - FETCH occupies cycle 1 and LOAD occupies cycle 2.
  - First out_valid is in cycle 3.
- Per word with out_ready held at 1: 2 overhead cycles plus NSEG beats, i.e. 18 cycles at the defaults.
- Hold rule: while out_valid && !out_ready, out_data, out_valid and out_last are held stable.
- out_valid never drops without a handshake, except on reset.
- done is asserted in the cycle after the last handshake. busy falls with done's falling edge, and a new start is accepted in the first IDLE cycle.
- num_words=0: done is asserted in cycle 1 after start, and RD_ADDR is unchanged.

## Test plan
- Single word: preload mem[5] with the segments 0x00000000..0x0000000F at indices 0..15, i.e. word = {32'hF,…,32'h0}. Issue start with base=5, num=1 and hold out_ready=1. Required: 16 beats with values 0..15 in cycles 3..18; out_last only on the value-15 beat; done in cycle 19.
- Wrap-around: base=255, num=2. Required: RD_ADDR sequence 255 then 0; 32 beats with mem[255]'s segments before mem[0]'s; out_last on beat 32 only.
- Backpressure: hold out_ready=0 for 5 cycles mid-word and toggle it randomly elsewhere. Required: out_data and out_last held while stalled; the full segment sequence arrives with no drops or duplicates.
- Zero count: start with num=0. Required: no FETCH and no change to RD_ADDR; done in cycle 1; busy high only in that cycle.
- Start while busy: pulse start with different base/num during SHIFT. Required: the command is ignored and the original stream completes unchanged.
- Reset mid-stream: assert rst_n=0 on beat 7 of a num=3 command. Required: all outputs return to 0 immediately with no done pulse; a fresh command after release streams correctly.
